// File: rtl/fetch_pc_gen.sv
// Fetch-stage PC generator with an in-order prediction queue.
// EX resolves queue entries oldest-first; a mispredict redirects the PC and flushes the queue.
module fetch_pc_gen #(
  parameter logic [31:0] RESET_PC = 32'h4000_0060,
  parameter int unsigned Q_DEPTH  = 4,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             btb_hit,
  input  logic [31:0]      btb_target,
  output logic [31:0]      pc_out,
  output logic             fetch_valid,
  output logic             pred_taken_out,
  input  logic             resolve_valid,
  input  logic             resolve_taken,
  input  logic [31:0]      resolve_target,
  output logic             mispredict,
  output logic             q_full,
  output logic             q_empty,
  output logic             resolve_err,
  output logic [CNT_W-1:0] br_count,
  output logic [CNT_W-1:0] mp_count
);

  localparam int unsigned PTR_W = (Q_DEPTH > 1) ? $clog2(Q_DEPTH) : 1;
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(Q_DEPTH);

  typedef struct packed {
    logic [31:0] pc;
    logic        taken;
    logic [31:0] target;
  } pred_t;

  pred_t             q_mem [Q_DEPTH];
  pred_t             head;
  logic [PTR_W-1:0]  rd_ptr, wr_ptr;
  logic [PTR_W:0]    count;
  logic [31:0]       pc_q;
  logic [31:0]       head_seq, act_next, pred_next;
  logic              accepted, issue, pop;

  assign head   = q_mem[rd_ptr];
  assign pc_out = pc_q;

  // NOTE: every always_comb output is assigned on every path, so no latch can be inferred.
  always_comb begin
    head_seq  = head.pc + 32'd4;
    act_next  = resolve_taken ? resolve_target : head_seq;
    pred_next = head.taken ? head.target : head_seq;
  end

  // Reset gates the status flags so they read as an empty queue while rst is high.
  assign q_empty        = rst | (count == '0);
  assign q_full         = ~rst & (count == FULL_CNT);
  assign accepted       = resolve_valid & ~q_empty;
  assign mispredict     = accepted & (act_next != pred_next);
  assign pop            = accepted & ~mispredict;
  assign issue          = ~rst & ~stall & ~q_full & ~mispredict;
  assign fetch_valid    = issue;
  assign pred_taken_out = issue & btb_hit;

  // NOTE: queue storage has no reset; only entries covered by count are ever read as valid.
  always_ff @(posedge clk) begin
    if (issue) q_mem[wr_ptr] <= '{pc: pc_q, taken: btb_hit, target: btb_target};
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q   <= RESET_PC;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (mispredict) begin
      pc_q   <= act_next;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (issue) begin
        pc_q   <= btb_hit ? btb_target : pc_q + 32'd4;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({issue, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      resolve_err <= 1'b0;
      br_count    <= '0;
      mp_count    <= '0;
    end else begin
      if (resolve_valid & q_empty) resolve_err <= 1'b1;
      if (accepted && br_count != '1) br_count <= br_count + 1'b1;
      if (mispredict && mp_count != '1) mp_count <= mp_count + 1'b1;
    end
  end

endmodule
